// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter / fetch sequencer with start/halt control and retire counter
module fetch_unit #(
    parameter int              PC_W       = 8,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter int              CNT_W      = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             branchf_i,
    input  logic             branchb_i,
    input  logic             done_i,
    input  logic [PC_W-1:0]  branch_offset_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             fetch_en_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] instr_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating increment: the count sticks at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            pc_q    <= START_ADDR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    pc_d    = START_ADDR;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_inc;
                // Halt outranks any branch; forward outranks backward.
                if (done_i) begin
                    state_d = ST_HALT;
                end else if (branchf_i) begin
                    pc_d = pc_q + branch_offset_i;
                end else if (branchb_i) begin
                    pc_d = pc_q - branch_offset_i;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = START_ADDR;
                cnt_d   = '0;
            end
        endcase
    end

    assign pc_o          = pc_q;
    assign fetch_en_o    = (state_q == ST_RUN);
    assign halted_o      = (state_q == ST_HALT);
    assign instr_count_o = cnt_q;

endmodule
